// File: rtl/amba_axi4_lite_regfile_slave.sv
// AXI4-Lite slave register file: NUM_REGS x 32-bit registers, independent AW/W holding slots, SLVERR outside the map.
// Define AMBA_AXI4_LITE_REGFILE_PROT_CHECK_EN to make register 0 secure (non-secure AxPROT[1]=1 accesses get SLVERR).
module amba_axi4_lite_regfile_slave #(
    parameter int ADDRESS_WIDTH = 28,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [ADDRESS_WIDTH-1:0] AWADDR,
    input  logic [2:0]               AWPROT,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [DATA_WIDTH-1:0]    WDATA,
    input  logic [DATA_WIDTH/8-1:0]  WSTRB,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    input  logic [ADDRESS_WIDTH-1:0] ARADDR,
    input  logic [2:0]               ARPROT,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [DATA_WIDTH-1:0]    RDATA,
    output logic [1:0]               RRESP,
    output logic                     RVALID,
    input  logic                     RREADY
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("amba_axi4_lite_regfile_slave: DATA_WIDTH must be 32");
    end
    if ((NUM_REGS < 2) || ((NUM_REGS & (NUM_REGS - 1)) != 0) || (IDX_W + 2 > ADDRESS_WIDTH)) begin : g_bad_num_regs
        $error("amba_axi4_lite_regfile_slave: NUM_REGS must be a power of two >= 2 that fits the address space");
    end

    logic [DATA_WIDTH-1:0]    regs [NUM_REGS];
    logic                     aw_full;
    logic                     w_full;
    logic [ADDRESS_WIDTH-1:0] aw_addr;
    logic [2:0]               aw_prot;
    logic [DATA_WIDTH-1:0]    w_data;
    logic [STRB_W-1:0]        w_strb;
    logic                     aw_hs;
    logic                     w_hs;
    logic                     ar_hs;
    logic                     commit;
    logic [IDX_W-1:0]         aw_idx;
    logic [IDX_W-1:0]         ar_idx;
    logic                     aw_in_range;
    logic                     ar_in_range;
    logic                     wr_ok;
    logic                     rd_ok;
    logic                     unused_bits;

    // READY depends only on slot occupancy, never on the incoming VALID.
    assign AWREADY = !aw_full;
    assign WREADY  = !w_full;
    assign ARREADY = !RVALID || RREADY;

    assign aw_hs  = AWVALID && !aw_full;
    assign w_hs   = WVALID && !w_full;
    assign ar_hs  = ARVALID && ARREADY;
    assign commit = aw_full && w_full && (!BVALID || BREADY);

    assign aw_idx = aw_addr[IDX_W+1:2];
    assign ar_idx = ARADDR[IDX_W+1:2];

    if (IDX_W + 2 < ADDRESS_WIDTH) begin : g_range_decode
        assign aw_in_range = ~|aw_addr[ADDRESS_WIDTH-1:IDX_W+2];
        assign ar_in_range = ~|ARADDR[ADDRESS_WIDTH-1:IDX_W+2];
    end else begin : g_full_map
        assign aw_in_range = 1'b1;
        assign ar_in_range = 1'b1;
    end

`ifdef AMBA_AXI4_LITE_REGFILE_PROT_CHECK_EN
    assign wr_ok = aw_in_range && !(aw_prot[1] && (aw_idx == '0));
    assign rd_ok = ar_in_range && !(ARPROT[1] && (ar_idx == '0));
`else
    assign wr_ok = aw_in_range;
    assign rd_ok = ar_in_range;
`endif

    // Byte-offset bits and unchecked protection bits carry no meaning here.
    assign unused_bits = ^{aw_prot, ARPROT, aw_addr[1:0], ARADDR[1:0]};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_full <= 1'b0;
            aw_addr <= '0;
            aw_prot <= '0;
        end else if (commit) begin
            aw_full <= 1'b0;
        end else if (aw_hs) begin
            aw_full <= 1'b1;
            aw_addr <= AWADDR;
            aw_prot <= AWPROT;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_full <= 1'b0;
            w_data <= '0;
            w_strb <= '0;
        end else if (commit) begin
            w_full <= 1'b0;
        end else if (w_hs) begin
            w_full <= 1'b1;
            w_data <= WDATA;
            w_strb <= WSTRB;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit && wr_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

    // A commit may coincide with the B handshake of the previous write.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            BVALID <= 1'b0;
            BRESP  <= RESP_OKAY;
        end else if (commit) begin
            BVALID <= 1'b1;
            BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (BREADY) begin
            BVALID <= 1'b0;
        end
    end

    // Reads sample the register array before any same-edge commit lands.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            RVALID <= 1'b0;
            RRESP  <= RESP_OKAY;
            RDATA  <= '0;
        end else if (ar_hs) begin
            RVALID <= 1'b1;
            RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            RDATA  <= rd_ok ? regs[ar_idx] : '0;
        end else if (RREADY) begin
            RVALID <= 1'b0;
        end
    end
endmodule

// File: tb/tb_amba_axi4_lite_regfile_slave.sv
// Scoreboard bench for amba_axi4_lite_regfile_slave: directed writes/reads push expected B/R beats,
// a negedge monitor pops and compares them; timing and ready/valid levels are checked inline.
module tb_amba_axi4_lite_regfile_slave;
    logic        ACLK;
    logic        ARESETn;
    logic [27:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [27:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    amba_axi4_lite_regfile_slave #(
        .ADDRESS_WIDTH(28),
        .DATA_WIDTH(32),
        .NUM_REGS(16)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one B and/or R beat is consumed at each handshake.
    always @(negedge ACLK) begin
        if (ARESETn && BVALID && BREADY) begin
            if (exp_b.size() == 0) check("b_unexpected", 64'(BVALID), 64'd0);
            else check("b_resp", 64'(BRESP), 64'(exp_b.pop_front()));
        end
        if (ARESETn && RVALID && RREADY) begin
            if (exp_r.size() == 0) check("r_unexpected", 64'(RVALID), 64'd0);
            else check("r_resp_data", 64'({RRESP, RDATA}), 64'(exp_r.pop_front()));
        end
    end

    task automatic drive_write(input bit do_aw, input bit do_w, input logic [27:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input logic [2:0] prot, input logic [1:0] exp_resp);
        bit aw_go;
        bit w_go;
        if (do_aw) exp_b.push_back(exp_resp);
        AWADDR  = addr;
        AWPROT  = prot;
        AWVALID = do_aw;
        WDATA   = data;
        WSTRB   = strb;
        WVALID  = do_w;
        for (int i = 0; i < 50 && (AWVALID || WVALID); i++) begin
            @(negedge ACLK);
            aw_go = AWVALID && AWREADY;
            w_go  = WVALID && WREADY;
            @(posedge ACLK);
            #1;
            if (aw_go) AWVALID = 1'b0;
            if (w_go) WVALID = 1'b0;
        end
        if (AWVALID || WVALID) begin
            check("write_handshake_timeout", 64'({AWVALID, WVALID}), 64'd0);
            AWVALID = 1'b0;
            WVALID  = 1'b0;
        end
    endtask

    task automatic drive_read(input logic [27:0] addr, input logic [2:0] prot,
                              input logic [1:0] exp_resp, input logic [31:0] exp_data);
        bit go;
        exp_r.push_back({exp_resp, exp_data});
        ARADDR  = addr;
        ARPROT  = prot;
        ARVALID = 1'b1;
        for (int i = 0; i < 50 && ARVALID; i++) begin
            @(negedge ACLK);
            go = ARREADY;
            @(posedge ACLK);
            #1;
            if (go) ARVALID = 1'b0;
        end
        if (ARVALID) begin
            check("read_handshake_timeout", 64'(ARVALID), 64'd0);
            ARVALID = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    initial begin
        ARESETn = 1'b0;
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b1;
        ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b1;
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        @(negedge ACLK);
        check("rst_awready", 64'(AWREADY), 64'd1);
        check("rst_wready", 64'(WREADY), 64'd1);
        check("rst_arready", 64'(ARREADY), 64'd1);
        check("rst_bvalid", 64'(BVALID), 64'd0);
        check("rst_rvalid", 64'(RVALID), 64'd0);
        check("rst_rdata_rresp_bresp", 64'({RDATA, RRESP, BRESP}), 64'd0);
        @(posedge ACLK);
        #1;

        // Same-cycle AW+W: BVALID low in cycle N+1, high in N+2.
        drive_write(1, 1, 28'h8, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00);
        @(negedge ACLK);
        check("b_latency_n1", 64'(BVALID), 64'd0);
        @(negedge ACLK);
        check("b_latency_n2", 64'(BVALID), 64'd1);
        @(posedge ACLK);
        #1;
        drive_read(28'h8, 3'b000, 2'b00, 32'hDEADBEEF);
        @(negedge ACLK);
        check("r_latency", 64'(RVALID), 64'd1);
        idle(1);

        // W leads AW by three cycles; strobes 0x5 merge into 0xFFFFFFFF.
        drive_write(1, 1, 28'h4, 32'hFFFFFFFF, 4'hF, 3'b000, 2'b00);
        idle(2);
        drive_write(0, 1, 28'h0, 32'h11223344, 4'h5, 3'b000, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check("w_early_wready", 64'(WREADY), 64'd0);
            check("w_early_awready", 64'(AWREADY), 64'd1);
        end
        @(posedge ACLK);
        #1;
        drive_write(1, 0, 28'h4, 32'h0, 4'h0, 3'b000, 2'b00);
        idle(2);
        drive_read(28'h4, 3'b000, 2'b00, 32'hFF22FF44);

        // Out of range: 0x40 is index 16; index bits alias register 0, which must stay 0.
        drive_write(1, 1, 28'h40, 32'h12345678, 4'hF, 3'b000, 2'b10);
        idle(2);
        drive_read(28'h40, 3'b000, 2'b10, 32'h0);
        drive_read(28'h0, 3'b000, 2'b00, 32'h0);
        // WSTRB=0 is an OKAY no-op.
        drive_write(1, 1, 28'h8, 32'h0, 4'h0, 3'b000, 2'b00);
        idle(2);

        // Back-to-back reads with ARVALID held high.
        ARVALID = 1'b1;
        ARPROT  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin ARADDR = 28'h8;  exp_r.push_back({2'b00, 32'hDEADBEEF}); end
                1: begin ARADDR = 28'h4;  exp_r.push_back({2'b00, 32'hFF22FF44}); end
                default: begin ARADDR = 28'h40; exp_r.push_back({2'b10, 32'h0}); end
            endcase
            @(negedge ACLK);
            check("b2b_arready", 64'(ARREADY), 64'd1);
            @(posedge ACLK);
            #1;
        end
        ARVALID = 1'b0;
        idle(1);

        // R stalled: data holds, ARREADY low.
        RREADY = 1'b0;
        drive_read(28'h4, 3'b000, 2'b00, 32'hFF22FF44);
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check("rstall_hold", 64'({RVALID, RRESP, RDATA}), 64'({1'b1, 2'b00, 32'hFF22FF44}));
            check("rstall_arready", 64'(ARREADY), 64'd0);
        end
        @(posedge ACLK);
        #1 RREADY = 1'b1;
        idle(2);

        // B stalled: second write parks in the slots, no commit until B drains.
        BREADY = 1'b0;
        drive_write(1, 1, 28'hC, 32'hAAAA0001, 4'hF, 3'b000, 2'b00);
        drive_write(1, 1, 28'h10, 32'hBBBB0002, 4'hF, 3'b000, 2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("bstall_bvalid_bresp", 64'({BVALID, BRESP}), 64'({1'b1, 2'b00}));
            check("bstall_slots_full", 64'({AWREADY, WREADY}), 64'd0);
        end
        @(posedge ACLK);
        #1;
        drive_read(28'h10, 3'b000, 2'b00, 32'h0);
        BREADY = 1'b1;
        idle(4);
        drive_read(28'hC, 3'b000, 2'b00, 32'hAAAA0001);
        drive_read(28'h10, 3'b000, 2'b00, 32'hBBBB0002);
        idle(1);

        // Commit and read of register 5 on the same edge: read sees the old value.
        AWADDR = 28'h14; AWPROT = 3'b000; AWVALID = 1'b1;
        WDATA = 32'h0BADF00D; WSTRB = 4'hF; WVALID = 1'b1;
        exp_b.push_back(2'b00);
        @(posedge ACLK);
        #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 28'h14; ARPROT = 3'b000; ARVALID = 1'b1;
        exp_r.push_back({2'b00, 32'h0});
        @(posedge ACLK);
        #1 ARVALID = 1'b0;
        idle(2);
        drive_read(28'h14, 3'b000, 2'b00, 32'h0BADF00D);
        idle(1);

        // Reset with both responses pending.
        BREADY = 1'b0;
        RREADY = 1'b0;
        drive_write(1, 1, 28'h18, 32'h55AA55AA, 4'hF, 3'b000, 2'b00);
        drive_read(28'h8, 3'b000, 2'b00, 32'hDEADBEEF);
        idle(2);
        @(negedge ACLK);
        check("pre_reset_valids", 64'({BVALID, RVALID}), 64'd3);
        #2 ARESETn = 1'b0;
        #1;
        check("reset_async_valids", 64'({BVALID, RVALID}), 64'd0);
        check("reset_async_rdata", 64'(RDATA), 64'd0);
        exp_b.delete();
        exp_r.delete();
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        BREADY  = 1'b1;
        RREADY  = 1'b1;
        @(negedge ACLK);
        check("post_reset_readies", 64'({AWREADY, WREADY, ARREADY}), 64'd7);
        @(posedge ACLK);
        #1;
        drive_read(28'h8, 3'b000, 2'b00, 32'h0);
        drive_read(28'h18, 3'b000, 2'b00, 32'h0);
        drive_read(28'h4, 3'b000, 2'b00, 32'h0);

`ifdef AMBA_AXI4_LITE_REGFILE_PROT_CHECK_EN
        drive_write(1, 1, 28'h0, 32'hCAFEF00D, 4'hF, 3'b010, 2'b10);
        idle(2);
        drive_read(28'h0, 3'b000, 2'b00, 32'h0);
        drive_write(1, 1, 28'h0, 32'hCAFEF00D, 4'hF, 3'b000, 2'b00);
        idle(2);
        drive_read(28'h0, 3'b000, 2'b00, 32'hCAFEF00D);
        drive_read(28'h0, 3'b010, 2'b10, 32'h0);
        drive_write(1, 1, 28'h1C, 32'h77777777, 4'hF, 3'b010, 2'b00);
        idle(2);
        drive_read(28'h1C, 3'b010, 2'b00, 32'h77777777);
`else
        drive_write(1, 1, 28'h0, 32'hCAFEF00D, 4'hF, 3'b010, 2'b00);
        idle(2);
        drive_read(28'h0, 3'b010, 2'b00, 32'hCAFEF00D);
`endif

        for (int i = 0; i < 50 && (exp_b.size() != 0 || exp_r.size() != 0); i++) @(posedge ACLK);
        idle(2);
        check("drain_b_queue", 64'(exp_b.size()), 64'd0);
        check("drain_r_queue", 64'(exp_r.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
